// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: operation codes and controller states.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative unsigned multiplier: one shift-add step per step_i cycle.
// product_o is the product as it will be after the current step, so the
// controller can latch the final value on the same edge as the last step.
module alu_shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic                         step_i,
    input  logic [WIDTH-1:0]             a_i,
    input  logic [WIDTH-1:0]             b_i,
    output logic [2*WIDTH-1:0]           product_o,
    output logic [$clog2(WIDTH+1)-1:0]   done_count_o
);

    localparam int CW = $clog2(WIDTH+1);

    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;

    // Add the shifted multiplicand when the current multiplier LSB is set.
    always_comb begin
        prod_d = prod_q;
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
    end

    // Operand capture on start, then one partial-product step per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (start_i) begin
            prod_q   <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            cnt_q    <= '0;
        end else if (step_i) begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
        end
    end

    assign product_o    = prod_d;
    assign done_count_o = cnt_q;

endmodule

// File: rtl/alu_unit.sv
// Single-issue ALU: one-cycle logic/arith ops, WIDTH-cycle iterative multiply.
// Result and flags are registered and only change when an operation completes.
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] REGA,
    input  logic [WIDTH-1:0] REGB,
    input  logic             EU,
    output logic [WIDTH-1:0] result,
    output logic             BUSY,
    output logic             DONE,
    output logic             CF,
    output logic             ZF,
    output logic             NF,
    output logic             VF
);

    localparam int         CW   = $clog2(WIDTH+1);
    localparam int         M    = WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               cf_q, zf_q, nf_q, vf_q, cf_d, vf_d;
    logic               busy_q, done_q;
    logic [WIDTH:0]     add_w, sub_w;
    logic [2*WIDTH-1:0] mul_prod;
    logic [CW-1:0]      mul_cnt;
    logic               mul_start, mul_step;

    assign add_w = {1'b0, REGA} + {1'b0, REGB};
    assign sub_w = {1'b0, REGA} - {1'b0, REGB};

    assign mul_start = (state_q == ST_IDLE) && START && (OP == OP_MUL);
    assign mul_step  = (state_q == ST_MUL);

    alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk          (CLK),
        .rst_n        (CLR),
        .start_i      (mul_start),
        .step_i       (mul_step),
        .a_i          (REGA),
        .b_i          (REGB),
        .product_o    (mul_prod),
        .done_count_o (mul_cnt)
    );

    // Single-cycle datapath; MUL is handled by the iterative unit.
    always_comb begin
        res_d = '0;
        cf_d  = 1'b0;
        vf_d  = 1'b0;
        case (OP)
            OP_ADD: begin
                res_d = add_w[WIDTH-1:0];
                cf_d  = add_w[WIDTH];
                vf_d  = (REGA[M] == REGB[M]) && (add_w[M] != REGA[M]);
            end
            OP_SUB: begin
                res_d = sub_w[WIDTH-1:0];
                cf_d  = sub_w[WIDTH];
                vf_d  = (REGA[M] != REGB[M]) && (sub_w[M] != REGA[M]);
            end
            OP_AND: res_d = REGA & REGB;
            OP_OR:  res_d = REGA | REGB;
            OP_XOR: res_d = REGA ^ REGB;
            OP_SHL: begin
                res_d = REGA << 1;
                cf_d  = REGA[M];
            end
            OP_SHR: begin
                res_d = REGA >> 1;
                cf_d  = REGA[0];
            end
            default: ;
        endcase
    end

    // Controller: accept in IDLE, iterate in MUL, pulse DONE for one cycle.
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            cf_q    <= 1'b0;
            zf_q    <= 1'b0;
            nf_q    <= 1'b0;
            vf_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        busy_q <= 1'b1;
                        if (OP == OP_MUL) begin
                            state_q <= ST_MUL;
                        end else begin
                            res_q   <= res_d;
                            cf_q    <= cf_d;
                            vf_q    <= vf_d;
                            zf_q    <= (res_d == '0);
                            nf_q    <= res_d[M];
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_cnt == LAST) begin
                        res_q   <= mul_prod[WIDTH-1:0];
                        cf_q    <= |mul_prod[2*WIDTH-1:WIDTH];
                        vf_q    <= 1'b0;
                        zf_q    <= (mul_prod[WIDTH-1:0] == '0);
                        nf_q    <= mul_prod[M];
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign result = EU ? res_q : '0;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign CF     = cf_q;
    assign ZF     = zf_q;
    assign NF     = nf_q;
    assign VF     = vf_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit at WIDTH=8; flags compared as {CF,ZF,NF,VF}.
module tb_alu_unit;

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic       START = 1'b0;
    logic [2:0] OP = 3'b000;
    logic [7:0] REGA = 8'h00;
    logic [7:0] REGB = 8'h00;
    logic       EU = 1'b1;
    logic [7:0] result;
    logic       BUSY, DONE, CF, ZF, NF, VF;

    int checks = 0;
    int errors = 0;

    alu_unit #(.WIDTH(8)) dut (
        .CLK(CLK), .CLR(CLR), .START(START), .OP(OP), .REGA(REGA), .REGB(REGB),
        .EU(EU), .result(result), .BUSY(BUSY), .DONE(DONE),
        .CF(CF), .ZF(ZF), .NF(NF), .VF(VF)
    );

    always #5 CLK = ~CLK;

    // Wait for IDLE, present one request, return 1ns after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge CLK);
        for (int i = 0; i < 20 && BUSY; i++) @(negedge CLK);
        OP = op; REGA = a; REGB = b; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic test_reset();
        CLR = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result: got %h exp 00", result); end
        checks++; if ({CF,ZF,NF,VF} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b exp 0000", {CF,ZF,NF,VF}); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", BUSY); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", DONE); end
        @(negedge CLK); CLR = 1'b1;
    endtask

    task automatic test_add();
        issue(3'b000, 8'hFF, 8'h01);
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL add_done: got %b exp 1", DONE); end
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL add_busy: got %b exp 1", BUSY); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL add_result: got %h exp 00", result); end
        checks++; if ({CF,ZF,NF,VF} !== 4'b1100) begin errors++; $display("FAIL add_flags: got %b exp 1100", {CF,ZF,NF,VF}); end
        @(posedge CLK); #1;
        checks++; if ({DONE,BUSY} !== 2'b00) begin errors++; $display("FAIL add_pulse: got done/busy %b exp 00", {DONE,BUSY}); end
    endtask

    task automatic test_sub();
        issue(3'b001, 8'h80, 8'h01);
        checks++; if (result !== 8'h7F) begin errors++; $display("FAIL sub1_result: got %h exp 7f", result); end
        checks++; if ({CF,ZF,NF,VF} !== 4'b0001) begin errors++; $display("FAIL sub1_flags: got %b exp 0001", {CF,ZF,NF,VF}); end
        issue(3'b001, 8'h03, 8'h05);
        checks++; if (result !== 8'hFE) begin errors++; $display("FAIL sub2_result: got %h exp fe", result); end
        checks++; if ({CF,ZF,NF,VF} !== 4'b1010) begin errors++; $display("FAIL sub2_flags: got %b exp 1010", {CF,ZF,NF,VF}); end
    endtask

    // Previous result is FE from test_sub; it must stay visible during MUL.
    task automatic test_mul();
        int ndone = 0, nbusy = 0, done_at = 0, hold_err = 0;
        logic [7:0] res_at_done = 8'h00;
        logic [3:0] flg_at_done = 4'b0000;
        issue(3'b111, 8'h10, 8'h11);
        REGA = 8'h55; REGB = 8'hAA;
        for (int i = 1; i <= 14; i++) begin
            if (DONE) begin ndone++; done_at = i; res_at_done = result; flg_at_done = {CF,ZF,NF,VF}; end
            if (BUSY) nbusy++;
            if (i < 9 && (result !== 8'hFE || {CF,ZF,NF,VF} !== 4'b1010)) hold_err++;
            if (i == 2) begin START = 1'b1; OP = 3'b000; end
            if (i == 3) START = 1'b0;
            @(posedge CLK); #1;
        end
        checks++; if (done_at !== 9) begin errors++; $display("FAIL mul_done_cycle: got %0d exp 9", done_at); end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL mul_done_count: got %0d exp 1", ndone); end
        checks++; if (nbusy !== 9) begin errors++; $display("FAIL mul_busy_cycles: got %0d exp 9", nbusy); end
        checks++; if (hold_err !== 0) begin errors++; $display("FAIL mul_hold: got %0d disturbed cycles exp 0", hold_err); end
        checks++; if (res_at_done !== 8'h10) begin errors++; $display("FAIL mul_result: got %h exp 10", res_at_done); end
        checks++; if (flg_at_done !== 4'b1000) begin errors++; $display("FAIL mul_flags: got %b exp 1000", flg_at_done); end
    endtask

    // Reset at the fourth multiply step, then START on the first edge out of reset.
    task automatic test_abort();
        int ndone = 0;
        issue(3'b111, 8'h0F, 8'h0F);
        for (int i = 0; i < 3; i++) begin
            if (DONE) ndone++;
            @(posedge CLK); #1;
        end
        if (DONE) ndone++;
        CLR = 1'b0;
        @(posedge CLK); #1;
        checks++; if (ndone !== 0 || DONE !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %0d/%b exp 0/0", ndone, DONE); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b exp 0", BUSY); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL abort_result: got %h exp 00", result); end
        checks++; if ({CF,ZF,NF,VF} !== 4'b0000) begin errors++; $display("FAIL abort_flags: got %b exp 0000", {CF,ZF,NF,VF}); end
        CLR = 1'b1; START = 1'b1; OP = 3'b000; REGA = 8'h02; REGB = 8'h03;
        @(posedge CLK); #1;
        START = 1'b0;
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL abort_restart_done: got %b exp 1", DONE); end
        checks++; if (result !== 8'h05) begin errors++; $display("FAIL abort_restart_result: got %h exp 05", result); end
        checks++; if ({CF,ZF,NF,VF} !== 4'b0000) begin errors++; $display("FAIL abort_restart_flags: got %b exp 0000", {CF,ZF,NF,VF}); end
    endtask

    task automatic test_eu();
        @(posedge CLK); #1;
        EU = 1'b0; #1;
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL eu_off_result: got %h exp 00", result); end
        checks++; if ({CF,ZF,NF,VF} !== 4'b0000) begin errors++; $display("FAIL eu_off_flags: got %b exp 0000", {CF,ZF,NF,VF}); end
        @(posedge CLK); #1;
        EU = 1'b1; #1;
        checks++; if (result !== 8'h05) begin errors++; $display("FAIL eu_on_result: got %h exp 05", result); end
    endtask

    task automatic test_shift();
        issue(3'b101, 8'h81, 8'h00);
        checks++; if (result !== 8'h02) begin errors++; $display("FAIL shl_result: got %h exp 02", result); end
        checks++; if ({CF,ZF,NF,VF} !== 4'b1000) begin errors++; $display("FAIL shl_flags: got %b exp 1000", {CF,ZF,NF,VF}); end
        issue(3'b110, 8'h01, 8'h00);
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL shr_result: got %h exp 00", result); end
        checks++; if ({CF,ZF,NF,VF} !== 4'b1100) begin errors++; $display("FAIL shr_flags: got %b exp 1100", {CF,ZF,NF,VF}); end
    endtask

    task automatic test_logic();
        issue(3'b010, 8'hF0, 8'h3C);
        checks++; if ({result,CF,ZF,NF,VF} !== {8'h30, 4'b0000}) begin errors++; $display("FAIL and_out: got %h/%b exp 30/0000", result, {CF,ZF,NF,VF}); end
        issue(3'b011, 8'hF0, 8'h0C);
        checks++; if ({result,CF,ZF,NF,VF} !== {8'hFC, 4'b0010}) begin errors++; $display("FAIL or_out: got %h/%b exp fc/0010", result, {CF,ZF,NF,VF}); end
        issue(3'b100, 8'hAA, 8'hAA);
        checks++; if ({result,CF,ZF,NF,VF} !== {8'h00, 4'b0100}) begin errors++; $display("FAIL xor_out: got %h/%b exp 00/0100", result, {CF,ZF,NF,VF}); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_abort();
        test_eu();
        test_shift();
        test_logic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
